fetch_unit_btb: RTL and testbench

// Parametrised instruction-fetch stage: PC register, PC+4 adder, next-PC select and a

---
 rtl/fetch_unit_btb.sv | 104 ++++++++++
 tb/tb_fetch_unit_btb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_btb.sv
// rtl/fetch_unit_btb.sv - fetch stage: PC register, PC+4, next-PC select, direct-mapped BTB
// with 2-bit saturating counters
module fetch_unit_btb #(
    parameter int                ADDR_W      = 32,
    parameter int                BTB_ENTRIES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] JumpDest,
    input  logic              Mispredict,
    input  logic [ADDR_W-1:0] CorrectPC,
    input  logic              ResolveValid,
    input  logic [ADDR_W-1:0] ResolvePC,
    input  logic              ResolveTaken,
    input  logic [ADDR_W-1:0] ResolveTarget,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic [ADDR_W-1:0] IMemData,
    output logic [ADDR_W-1:0] Instruction,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [ADDR_W-1:0] PCI_Out,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredTarget
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;

    logic              btb_valid  [BTB_ENTRIES];
    logic [1:0]        btb_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
    logic [ADDR_W-1:0] btb_target [BTB_ENTRIES];

    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic              look_hit;
    logic [IDX_W-1:0]  res_idx;
    logic [TAG_W-1:0]  res_tag;
    logic              res_hit;

    assign pc_inc      = pc + ADDR_W'(4);
    assign PC_Out      = pc;
    assign PCI_Out     = pc_inc;
    assign IMemAddr    = pc;
    assign Instruction = IMemData;

    // Lookup reads the array state before this edge's update, so same-index
    // lookup and resolve in one cycle naturally see the old entry.
    assign look_idx   = pc[IDX_W+1:2];
    assign look_tag   = pc[ADDR_W-1:IDX_W+2];
    assign look_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    assign PredTaken  = look_hit && btb_ctr[look_idx][1];
    assign PredTarget = PredTaken ? btb_target[look_idx] : '0;

    assign res_idx = ResolvePC[IDX_W+1:2];
    assign res_tag = ResolvePC[ADDR_W-1:IDX_W+2];
    assign res_hit = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);

    always_comb begin
        pc_next = pc_inc;
        if (Mispredict)        pc_next = CorrectPC;
        else if (Jump)         pc_next = JumpDest;
        else if (!WriteEnable) pc_next = pc;
        else if (PredTaken)    pc_next = PredTarget;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) pc <= RESET_PC;
        else       pc <= pc_next;
    end

    // Training runs regardless of stall/redirect: EX resolution is always committed.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_ctr[i]    <= 2'b01;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (ResolveValid) begin
            if (res_hit) begin
                if (ResolveTaken) begin
                    if (btb_ctr[res_idx] != 2'b11) btb_ctr[res_idx] <= btb_ctr[res_idx] + 2'b01;
                    btb_target[res_idx] <= ResolveTarget;
                end else if (btb_ctr[res_idx] != 2'b00) begin
                    btb_ctr[res_idx] <= btb_ctr[res_idx] - 2'b01;
                end
            end else if (ResolveTaken) begin
                btb_valid[res_idx]  <= 1'b1;
                btb_tag[res_idx]    <= res_tag;
                btb_target[res_idx] <= ResolveTarget;
                btb_ctr[res_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit_btb.sv
// tb/tb_fetch_unit_btb.sv - randomized and directed bench for fetch_unit_btb against a
// word-address reference model
module tb_fetch_unit_btb;

    localparam logic [31:0] RPC = 32'h100;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        WriteEnable, Jump, Mispredict, ResolveValid, ResolveTaken;
    logic [31:0] JumpDest, CorrectPC, ResolvePC, ResolveTarget;
    logic [31:0] IMemAddr, IMemData, Instruction, PC_Out, PCI_Out, PredTarget;
    logic        PredTaken;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    fetch_unit_btb #(.ADDR_W(32), .BTB_ENTRIES(16), .RESET_PC(RPC)) dut (
        .Clock(Clock), .Reset(Reset), .WriteEnable(WriteEnable),
        .Jump(Jump), .JumpDest(JumpDest),
        .Mispredict(Mispredict), .CorrectPC(CorrectPC),
        .ResolveValid(ResolveValid), .ResolvePC(ResolvePC),
        .ResolveTaken(ResolveTaken), .ResolveTarget(ResolveTarget),
        .IMemAddr(IMemAddr), .IMemData(IMemData), .Instruction(Instruction),
        .PC_Out(PC_Out), .PCI_Out(PCI_Out),
        .PredTaken(PredTaken), .PredTarget(PredTarget)
    );

    always #5 Clock = ~Clock;

    assign IMemData = IMemAddr ^ 32'hA5A5_0000;

    // Model: each slot remembers the full word address of the branch it holds.
    logic [31:0] m_pc;
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    int          m_ctr   [16];
    logic [31:0] m_tgt   [16];

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) % 32'd16);
    endfunction

    function automatic bit m_taken();
        int s = slot(m_pc);
        return m_valid[s] && (m_word[s] == m_pc[31:2]) && (m_ctr[s] >= 2);
    endfunction

    function automatic logic [31:0] m_target();
        return m_taken() ? m_tgt[slot(m_pc)] : 32'h0;
    endfunction

    always @(posedge Clock or posedge Reset) begin : model
        logic [31:0] nxt;
        int s;
        if (Reset) begin
            m_pc = RPC;
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0; m_word[i] = '0; m_ctr[i] = 1; m_tgt[i] = '0;
            end
        end else begin
            if (Mispredict)        nxt = CorrectPC;
            else if (Jump)         nxt = JumpDest;
            else if (!WriteEnable) nxt = m_pc;
            else if (m_taken())    nxt = m_target();
            else                   nxt = m_pc + 32'd4;
            if (ResolveValid) begin
                s = slot(ResolvePC);
                if (m_valid[s] && m_word[s] == ResolvePC[31:2]) begin
                    if (ResolveTaken) begin
                        m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = ResolveTarget;
                    end else begin
                        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (ResolveTaken) begin
                    m_valid[s] = 1'b1; m_word[s] = ResolvePC[31:2];
                    m_ctr[s] = 2; m_tgt[s] = ResolveTarget;
                end
            end
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (cmp_en) begin
            chk("pc_out",      PC_Out,             m_pc);
            chk("imem_addr",   IMemAddr,           m_pc);
            chk("pci_out",     PCI_Out,            m_pc + 32'd4);
            chk("instruction", Instruction,        m_pc ^ 32'hA5A5_0000);
            chk("pred_taken",  {31'b0, PredTaken}, {31'b0, m_taken()});
            chk("pred_target", PredTarget,         m_target());
        end
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    task automatic idle();
        WriteEnable = 1'b1; Jump = 1'b0; Mispredict = 1'b0; ResolveValid = 1'b0;
        ResolveTaken = 1'b0; JumpDest = '0; CorrectPC = '0; ResolvePC = '0; ResolveTarget = '0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        Jump = 1'b1; JumpDest = a;
        step();
        Jump = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] p, input bit t, input logic [31:0] tg);
        ResolveValid = 1'b1; ResolvePC = p; ResolveTaken = t; ResolveTarget = tg;
        step();
        ResolveValid = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        return 32'($urandom_range(0, 47)) << 2;
    endfunction

    initial begin
        idle();
        Reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (2) step();
        Reset = 1'b0;

        // T1: sequential fetch from RESET_PC
        chk("t1_pc0", PC_Out, 32'h100);
        chk("t1_pci0", PCI_Out, 32'h104);
        step(); chk("t1_pc1", PC_Out, 32'h104);
        step(); chk("t1_pc2", PC_Out, 32'h108);
        chk("t1_pred", {31'b0, PredTaken}, 32'h0);

        // T2: allocate on taken miss, then predict
        resolve(32'h10, 1'b1, 32'h40);
        jump_to(32'h10);
        chk("t2_pred", {31'b0, PredTaken}, 32'h1);
        chk("t2_tgt", PredTarget, 32'h40);
        step(); chk("t2_follow", PC_Out, 32'h40);

        // T3: decrement to 00, then saturate at 11
        resolve(32'h10, 1'b0, 32'h0);
        resolve(32'h10, 1'b0, 32'h0);
        jump_to(32'h10);
        chk("t3_not_taken", {31'b0, PredTaken}, 32'h0);
        step(); chk("t3_seq", PC_Out, 32'h14);
        repeat (5) resolve(32'h10, 1'b1, 32'h80);
        jump_to(32'h10);
        chk("t3_sat_pred", {31'b0, PredTaken}, 32'h1);
        chk("t3_sat_tgt", PredTarget, 32'h80);

        // T4: alias at same index with different tag
        jump_to(32'h50);
        chk("t4_alias", {31'b0, PredTaken}, 32'h0);
        step(); chk("t4_seq", PC_Out, 32'h54);
        resolve(32'h10, 1'b0, 32'h0);
        jump_to(32'h10);
        chk("t3_ctr10", {31'b0, PredTaken}, 32'h1);
        resolve(32'h10, 1'b0, 32'h0);
        jump_to(32'h10);
        chk("t3_ctr01", {31'b0, PredTaken}, 32'h0);

        // T5: redirect priority and stall
        Mispredict = 1'b1; CorrectPC = 32'h200; Jump = 1'b1; JumpDest = 32'h300; WriteEnable = 1'b0;
        step();
        Mispredict = 1'b0;
        chk("t5_mispredict", PC_Out, 32'h200);
        step();
        Jump = 1'b0;
        chk("t5_jump_stall", PC_Out, 32'h300);
        for (int i = 0; i < 3; i++) begin
            step(); chk("t5_hold", PC_Out, 32'h300);
        end
        WriteEnable = 1'b1;

        // T6: async reset mid-cycle with trained BTB, then PC+4 wrap
        resolve(32'h10, 1'b1, 32'h40);
        resolve(32'h10, 1'b1, 32'h40);
        jump_to(32'h40);
        chk("t6_pre", PC_Out, 32'h40);
        Reset = 1'b1;
        #1;
        chk("t6_async_pc", PC_Out, 32'h100);
        chk("t6_async_pci", PCI_Out, 32'h104);
        ResolveValid = 1'b1; ResolvePC = 32'h10; ResolveTaken = 1'b1; ResolveTarget = 32'h44;
        step(); step();
        ResolveValid = 1'b0; Reset = 1'b0;
        chk("t6_held", PC_Out, 32'h100);
        jump_to(32'h10);
        chk("t6_cleared", {31'b0, PredTaken}, 32'h0);
        jump_to(32'hFFFF_FFFC);
        chk("t6_wrap_pci", PCI_Out, 32'h0);
        step(); chk("t6_wrap_pc", PC_Out, 32'h0);

        // Random traffic over a small aliased address window
        for (int n = 0; n < 3000; n++) begin
            Mispredict    = ($urandom_range(0, 99) < 4);
            CorrectPC     = pick_addr();
            Jump          = ($urandom_range(0, 99) < 6);
            JumpDest      = pick_addr();
            WriteEnable   = ($urandom_range(0, 99) < 85);
            ResolveValid  = ($urandom_range(0, 99) < 40);
            ResolvePC     = pick_addr() | 32'($urandom_range(0, 3));
            ResolveTaken  = $urandom_range(0, 1) == 1;
            ResolveTarget = pick_addr();
            if ($urandom_range(0, 299) == 0) Reset = 1'b1;
            step();
            Reset = 1'b0;
        end

        idle();
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
